// File: rtl/multdiv_seq.sv
// Sequencer for execute-stage HI/LO arithmetic: fixed-latency multiply/accumulate
// and a 32-step restoring divider, holding the {hi,lo} result until execute advances.
module multdiv_seq #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        advance,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        ok,
   output logic        busy
);

   localparam int CNT_MAX = (MUL_LAT > 32) ? MUL_LAT : 32;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(32);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]       op_q;
   logic [31:0]      a_q, b_q;
   logic [63:0]      acc_q;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rem_q, quo_q, divisor_q;

   logic        is_div_req;
   logic        last_step;
   logic [31:0] dvd_mag, dvs_mag;

   logic        mul_signed;
   logic [63:0] a_wide, b_wide, product, mul_res;

   logic [32:0] shifted;
   logic [32:0] low_diff;
   logic        sub_ok;
   logic [31:0] rem_nxt, quo_nxt, quo_res, rem_res;
   logic        neg_quo, neg_rem;

   assign busy       = req_valid & ~ok & ~flush;
   assign is_div_req = (op[2:1] == 2'b01);
   assign last_step  = (cnt == CNT_ONE);

   // Only signed DIV works on magnitudes; DIVU and the multiply ops ignore these.
   assign dvd_mag = ((op == 3'd2) && a[31]) ? (32'd0 - a) : a;
   assign dvs_mag = ((op == 3'd2) && b[31]) ? (32'd0 - b) : b;

   // Operands are frozen while in MUL, so the multiplier is a MUL_LAT-cycle path.
   // Low 64 bits of the 64-bit-extended product equal those of the 33x33 product.
   assign mul_signed = ~op_q[0];
   assign a_wide     = {{32{mul_signed & a_q[31]}}, a_q};
   assign b_wide     = {{32{mul_signed & b_q[31]}}, b_q};
   assign product    = a_wide * b_wide;

   always_comb begin
      mul_res = product;
      if (op_q[2]) begin
         mul_res = op_q[1] ? (acc_q - product) : (acc_q + product);
      end
   end

   // One restoring step: when the shifted remainder reaches 2^32 it must exceed
   // any divisor, otherwise the borrow of the low 32-bit subtract decides.
   assign shifted  = {rem_q, quo_q[31]};
   assign low_diff = {1'b0, shifted[31:0]} - {1'b0, divisor_q};
   assign sub_ok   = shifted[32] | ~low_diff[32];
   assign rem_nxt  = sub_ok ? low_diff[31:0] : shifted[31:0];
   assign quo_nxt  = {quo_q[30:0], sub_ok};

   assign neg_quo  = ~op_q[0] & (a_q[31] ^ b_q[31]);
   assign neg_rem  = ~op_q[0] & a_q[31];
   assign quo_res  = neg_quo ? (32'd0 - quo_nxt) : quo_nxt;
   assign rem_res  = neg_rem ? (32'd0 - rem_nxt) : rem_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Flush wins over both acceptance and advance; DONE only leaves on advance.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state_nxt = is_div_req ? DIV : MUL;
               end
            end
            MUL: begin
               if (last_step) begin
                  state_nxt = DONE;
               end
            end
            DIV: begin
               if (last_step) begin
                  state_nxt = DONE;
               end
            end
            DONE: begin
               if (advance) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q      <= 3'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         acc_q     <= 64'd0;
         cnt       <= '0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         divisor_q <= 32'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         ok        <= 1'b0;
      end else if (flush) begin
         ok <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= op;
                  a_q       <= a;
                  b_q       <= b;
                  acc_q     <= {hi_in, lo_in};
                  cnt       <= is_div_req ? DIV_CNT : MUL_CNT;
                  rem_q     <= 32'd0;
                  quo_q     <= dvd_mag;
                  divisor_q <= dvs_mag;
               end
            end
            MUL: begin
               cnt <= cnt - CNT_ONE;
               if (last_step) begin
                  hi <= mul_res[63:32];
                  lo <= mul_res[31:0];
                  ok <= 1'b1;
               end
            end
            DIV: begin
               cnt   <= cnt - CNT_ONE;
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               if (last_step) begin
                  hi <= rem_res;
                  lo <= quo_res;
                  ok <= 1'b1;
               end
            end
            DONE: begin
               if (advance) begin
                  ok <= 1'b0;
               end
            end
            default: ok <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed vectors push expected {hi,lo} and
// completion cycle; a negedge monitor pops and checks each time ok rises.
module tb_multdiv_seq;

   localparam int MUL_LAT = 2;
   localparam int LAT_MUL = MUL_LAT + 1;
   localparam int LAT_DIV = 33;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic [2:0]  op;
   logic [31:0] a, b, hi_in, lo_in;
   logic        advance;
   logic        flush;
   logic [31:0] hi, lo;
   logic        ok;
   logic        busy;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   bit   ok_seen = 0;

   multdiv_seq #(.MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .op        (op),
      .a         (a),
      .b         (b),
      .hi_in     (hi_in),
      .lo_in     (lo_in),
      .advance   (advance),
      .flush     (flush),
      .hi        (hi),
      .lo        (lo),
      .ok        (ok),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total = total + 1;
      if (actual !== expected) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Result monitor: each rising ok must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (ok && !ok_seen) begin
         ok_seen = 1'b1;
         if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL unexpected_ok: got ok=1 expected no result pending");
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput({mon_e.name, "_hi"}, hi, mon_e.hi);
            checkOutput({mon_e.name, "_lo"}, lo, mon_e.lo);
            checkOutput({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
         end
      end else if (!ok) begin
         ok_seen = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] ia, ib, ihi, ilo);
      @(negedge clk);
      op        = o;
      a         = ia;
      b         = ib;
      hi_in     = ihi;
      lo_in     = ilo;
      advance   = 1'b0;
      req_valid = 1'b1;
      acc_cyc   = cyc;
      @(posedge clk);
   endtask

   task automatic expectResult(input string name, input logic [31:0] eh, el, input int lat);
      exp_t e;
      e.hi   = eh;
      e.lo   = el;
      e.due  = acc_cyc + lat;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Scrambles the inputs while the operation runs, optionally holds DONE, then advances.
   task automatic waitDone(input int hold, input logic [31:0] eh, el);
      int n    = 0;
      bit seen = 0;
      while (!seen && n < LAT_DIV + 10) begin
         @(negedge clk);
         if (ok) begin
            seen = 1;
         end else begin
            checkOutput("busy_running", 32'(busy), 32'd1);
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
            hi_in = $urandom;
            lo_in = $urandom;
            n++;
         end
      end
      if (!seen) begin
         total = total + 1;
         bad   = bad + 1;
         $display("[TB] FAIL done_timeout: got ok=0 expected ok=1 within %0d cycles", LAT_DIV + 10);
      end else begin
         checkOutput("busy_done", 32'(busy), 32'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_ok", 32'(ok), 32'd1);
            checkOutput("hold_hi", hi, eh);
            checkOutput("hold_lo", lo, el);
         end
      end
      advance = 1'b1;
      @(posedge clk);
      #1;
      advance   = 1'b0;
      req_valid = 1'b0;
      checkOutput("ok_after_advance", 32'(ok), 32'd0);
   endtask

   task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] ia, ib, ihi, ilo,
                        input logic [31:0] eh, el, input int hold);
      applyStimulus(o, ia, ib, ihi, ilo);
      expectResult(name, eh, el, (o[2:1] == 2'b01) ? LAT_DIV : LAT_MUL);
      waitDone(hold, eh, el);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      req_valid = 1'b0;
      op        = 3'd0;
      a         = 32'd0;
      b         = 32'd0;
      hi_in     = 32'd0;
      lo_in     = 32'd0;
      advance   = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      checkOutput("reset_ok", 32'(ok), 32'd0);
      checkOutput("reset_busy_idle", 32'(busy), 32'd0);
      req_valid = 1'b1;
      #1;
      checkOutput("reset_busy_req", 32'(busy), 32'd1);
      req_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      runOp("mult",     3'd0, 32'hFFFFFFFD, 32'd5,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      runOp("multu",    3'd1, 32'hFFFFFFFD, 32'd5,        32'd0, 32'd0,        32'h00000004, 32'hFFFFFFF1, 0);
      runOp("multu_max",3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, 0);
      runOp("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'd0, 32'd0,        32'h40000000, 32'h00000000, 0);
      runOp("maddu",    3'd5, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
      runOp("msub",     3'd6, 32'd1,        32'd1,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      runOp("madd",     3'd4, 32'hFFFFFFFE, 32'd3,        32'd1, 32'd0,        32'h00000000, 32'hFFFFFFFA, 0);
      runOp("msubu",    3'd7, 32'd3,        32'd4,        32'd0, 32'd10,       32'hFFFFFFFF, 32'hFFFFFFFE, 0);
      runOp("div_neg",  3'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      runOp("divu",     3'd3, 32'd100,      32'd7,        32'd0, 32'd0,        32'h00000002, 32'h0000000E, 0);
      runOp("divu_zero",3'd3, 32'h80000000, 32'd0,        32'd0, 32'd0,        32'h80000000, 32'hFFFFFFFF, 0);
      runOp("div_zero", 3'd2, 32'hFFFFFFF9, 32'd0,        32'd0, 32'd0,        32'hFFFFFFF9, 32'h00000001, 0);
      runOp("div_nn",   3'd2, 32'hFFFFFF9C, 32'd7,        32'd0, 32'd0,        32'hFFFFFFFE, 32'hFFFFFFF2, 0);
      runOp("div_pn",   3'd2, 32'd100,      32'hFFFFFFF9, 32'd0, 32'd0,        32'h00000002, 32'hFFFFFFF2, 0);

      // Reset in the middle of a divide, with the request still held afterwards.
      applyStimulus(3'd3, 32'd100, 32'd7, 32'd0, 32'd0);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("midreset_hi", hi, 32'd0);
      checkOutput("midreset_lo", lo, 32'd0);
      checkOutput("midreset_ok", 32'(ok), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      resetn  = 1'b1;
      acc_cyc = cyc;
      @(posedge clk);
      expectResult("div_after_reset", 32'd2, 32'd14, LAT_DIV);
      waitDone(0, 32'd2, 32'd14);

      // Flush a divide ten cycles in, then a multiply the next cycle, held in DONE.
      applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      checkOutput("flush_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_ok", 32'(ok), 32'd0);
      checkOutput("flush_hi", hi, 32'd2);
      checkOutput("flush_lo", lo, 32'd14);
      runOp("mult_after_flush", 3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 32'h00000000, 32'h0000002A, 5);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Sequencer for the execute stage's HI/LO arithmetic. It accepts one multiply, divide or multiply-accumulate request at a time from execute and latches the operands. Multiplies run through a fixed-latency product pipeline; divides run on an internal 32-iteration restoring divider. The block asserts `ok` and holds the 64-bit {hi,lo} result until the pipeline advances. Hazard logic stalls execute on `busy`.

## Interface
- `MUL_LAT`, default 2: multiply pipeline depth in cycles. Must be at least 1.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute holds a mult/div-class instruction.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `a`, `b` in 32 each: forwarded rs and rt operands.
- `hi_in`, `lo_in` in 32 each: current HI/LO accumulator for MADD/MSUB.
- `advance` in 1: execute register moves to memory this cycle.
- `flush` in 1: kill the in-flight operation.
- `hi`, `lo` out 32 each: result. Registered; stable while `ok`=1.
- `ok` out 1: result valid for the current request. Registered.
- `busy` out 1: equals `req_valid & ~ok & ~flush`. Combinational stall request.

## Operation
- States: IDLE, MUL, DIV, DONE. On reset the state is IDLE, `hi`=`lo`=0 and `ok`=0.
- IDLE, with `req_valid & ~flush`:
  - latch `op`, `a`, `b`, `hi_in`, `lo_in`.
  - ops 0,1,4–7 go to MUL with the counter set to MUL_LAT.
  - ops 2,3 go to DIV with the counter set to 32.
- Operand changes after acceptance are ignored.
- MUL:
  - Product is 33×33 signed on extended operands: sign-extended for ops 0, 4 and 6; zero-extended for 1, 5 and 7. Keep the low 64 bits.
  - The counter decrements each cycle. At 1, the state goes to DONE and {hi,lo} is loaded with:
    - product for ops 0,1;
    - {hi_in,lo_in} + product for ops 4,5;
    - {hi_in,lo_in} − product for ops 6,7.
  - All sums are modulo 2^64.
- DIV:
  - DIV (op 2) uses operand magnitudes; DIVU (op 3) uses the raw operands.
  - Each cycle runs one restoring step: shift the remainder left by one, bring in the next dividend bit, then subtract the divisor if the result is non-negative. The quotient bit is set on subtract.
  - After 32 steps the state goes to DONE, with `lo` = quotient and `hi` = remainder.
  - Signed fix-up is combinational on that edge: negate the quotient if a[31]^b[31]; negate the remainder if a[31].
  - Divide by zero is not trapped. It yields the restoring result: quotient 0xFFFFFFFF and remainder equal to the dividend magnitude, then the signed fix-up.
- DONE:
  - `ok`=1; `hi`/`lo` held.
  - `advance` returns the state to IDLE with `ok`=0. Without `advance` the block stays in DONE indefinitely and never restarts, even though `req_valid` stays high.
- `flush` in any state goes to IDLE on the next edge, with `ok`=0 and `hi`/`lo` unchanged. Flush has priority over acceptance and over `advance`.
- `flush` in IDLE with `req_valid` high: the request is not accepted.
- `resetn` low at any point asynchronously forces the reset values, including mid-MUL and mid-DIV. Counter and latched operands are cleared.

## Timing
- Request accepted at the edge ending cycle T.
- Multiply class: `ok`=1 from cycle T+MUL_LAT+1 (T+3 at the default).
- Divide: `ok`=1 from cycle T+33.
- `busy` tracks `req_valid` combinationally and falls in the same cycle `ok` rises.
- `advance` sampled in cycle D leaves `ok`=0 in D+1. The next instruction, in execute from D+1, is accepted at the edge ending D+1.
- Minimum spacing between two accepted requests is L+2 cycles, where L is the compute latency.
- Combinational paths: only `req_valid`/`ok`/`flush` to `busy`. No other input-to-output paths.

## Test plan
- MULT, a=0xFFFFFFFD (−3), b=5:
  - `ok` rises exactly at T+3 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU with the same operands gives hi=0x00000004, lo=0xFFFFFFF1.
- DIV, a=0xFFFFFFF9 (−7), b=2:
  - `ok` rises at T+33 with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 gives lo=14, hi=2.
- DIVU, a=0x80000000, b=0: lo=0xFFFFFFFF, hi=0x80000000; no hang, `ok` at T+33.
- Accumulate:
  - MADDU with hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 gives hi=1, lo=0.
  - MSUB with hi_in=lo_in=0, a=1, b=1 gives hi=lo=0xFFFFFFFF.
- Flush, then stall:
  - `flush` at T+10 of a DIV: `ok` stays 0 and hi/lo keep their old values. A new MULT presented the next cycle completes correctly.
  - With `advance` held low for 5 cycles in DONE: `ok`, hi and lo stay stable and no second operation starts.
- Reset: `resetn` low at T+5 of a DIV gives immediate hi=lo=0, `ok`=0, `busy`=`req_valid`. After release, the held request restarts and completes at 33 cycles.
